mc_control: RTL and testbench

Multi-cycle main controller for the MIPS datapath. Replaces single-cycle opcode decoding with a state machine that sequences fetch, decode, execute, memory and write-back over several clocks. It handshakes with instruction and data memories that can stall, and counts retired instructions. It sits beside PC, Registers, ALU_Control and the RegDst/ALUSrc muxes and drives their enables and selects.

---
 rtl/mc_pkg.sv | 27 ++
 rtl/mc_opdecode.sv | 24 ++
 rtl/mc_control.sv | 158 +++++++++++++++
 tb/tb_mc_control.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multi-cycle MIPS controller.
//   state_t   : controller state encoding (3 bits, IDLE=0 .. TRAP=6)
//   OP_*      : supported instruction[31:26] opcodes
//   ALUOP_*   : ALUOp encodings sent to ALU_Control
package mc_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_opdecode.sv
// mc_opdecode: combinational opcode classifier.
//   op      in  6  instruction opcode field
//   is_*    out 1  one-hot class of a supported opcode
//   illegal out 1  opcode is not one of the supported five
module mc_opdecode
   import mc_pkg::*;
(
   input  logic [5:0] op,
   output logic       is_r,
   output logic       is_addi,
   output logic       is_lw,
   output logic       is_sw,
   output logic       is_beq,
   output logic       illegal
);

   assign is_r    = (op == OP_RTYPE);
   assign is_addi = (op == OP_ADDI);
   assign is_lw   = (op == OP_LW);
   assign is_sw   = (op == OP_SW);
   assign is_beq  = (op == OP_BEQ);
   assign illegal = ~(is_r | is_addi | is_lw | is_sw | is_beq);

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle main controller for the MIPS datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, handshakes with stallable instruction
// and data memories, traps on illegal opcodes and counts retired instructions.
//   clk_i, rst_i (sync, active-high), start_i (run level, sampled in IDLE/retire)
//   op_i, imem_ready_i, dmem_ready_i, zero_i : datapath/memory status
//   imem_req_o, ir_write_o, pc_write_o, pc_branch_o, reg_write_o, reg_dst_o,
//   alu_src_o, alu_op_o, dmem_req_o, dmem_we_o, mem_to_reg_o : datapath controls
//   busy_o, illegal_o, retired_o : status
module mc_control
   import mc_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [5:0]  op_i,
   input  logic        imem_ready_i,
   input  logic        dmem_ready_i,
   input  logic        zero_i,
   output logic        imem_req_o,
   output logic        ir_write_o,
   output logic        pc_write_o,
   output logic        pc_branch_o,
   output logic        reg_write_o,
   output logic        reg_dst_o,
   output logic        alu_src_o,
   output logic [1:0]  alu_op_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic        mem_to_reg_o,
   output logic        busy_o,
   output logic        illegal_o,
   output logic [31:0] retired_o
);

   state_t      state_q, state_d;
   logic [5:0]  op_q;
   logic [31:0] retired_q;
   logic        retire;

   // Classifier on the live opcode: only its illegal flag steers DECODE.
   logic in_r, in_addi, in_lw, in_sw, in_beq, in_illegal;
   mc_opdecode u_dec_in (
      .op      (op_i),
      .is_r    (in_r),
      .is_addi (in_addi),
      .is_lw   (in_lw),
      .is_sw   (in_sw),
      .is_beq  (in_beq),
      .illegal (in_illegal)
   );
   logic unused_in_class;
   assign unused_in_class = in_r | in_addi | in_lw | in_sw | in_beq;

   // Classifier on the latched opcode drives all output decode.
   logic q_r, q_addi, q_lw, q_sw, q_beq, q_illegal;
   mc_opdecode u_dec_q (
      .op      (op_q),
      .is_r    (q_r),
      .is_addi (q_addi),
      .is_lw   (q_lw),
      .is_sw   (q_sw),
      .is_beq  (q_beq),
      .illegal (q_illegal)
   );
   logic unused_q_illegal;
   assign unused_q_illegal = q_illegal;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         op_q      <= 6'd0;
         retired_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) op_q <= op_i;
         if (retire) retired_q <= retired_q + 32'd1;
      end
   end

   always_comb begin
      state_d      = state_q;
      retire       = 1'b0;
      imem_req_o   = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      pc_branch_o  = 1'b0;
      reg_write_o  = 1'b0;
      reg_dst_o    = 1'b0;
      alu_src_o    = 1'b0;
      alu_op_o     = ALUOP_ADD;
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      mem_to_reg_o = 1'b0;

      case (state_q)
         S_IDLE: if (start_i) state_d = S_FETCH;

         S_FETCH: begin
            imem_req_o = 1'b1;
            if (imem_ready_i) begin
               ir_write_o = 1'b1;
               pc_write_o = 1'b1;
               state_d    = S_DECODE;
            end
         end

         S_DECODE: state_d = in_illegal ? S_TRAP : S_EXEC;

         S_EXEC: begin
            if (q_r) begin
               alu_op_o = ALUOP_FUNCT;
               state_d  = S_WB;
            end else if (q_addi) begin
               alu_src_o = 1'b1;
               state_d   = S_WB;
            end else if (q_lw || q_sw) begin
               alu_src_o = 1'b1;
               state_d   = S_MEM;
            end else if (q_beq) begin
               alu_op_o    = ALUOP_SUB;
               pc_branch_o = zero_i;
               retire      = 1'b1;
            end else begin
               // op_q is only ever loaded with a legal opcode before EXEC
               state_d = S_TRAP;
            end
         end

         S_MEM: begin
            dmem_req_o = 1'b1;
            dmem_we_o  = q_sw;
            if (dmem_ready_i) begin
               if (q_lw) state_d = S_WB;
               else      retire  = 1'b1;
            end
         end

         S_WB: begin
            reg_write_o  = 1'b1;
            reg_dst_o    = q_r;
            mem_to_reg_o = q_lw;
            retire       = 1'b1;
         end

         S_TRAP: state_d = S_TRAP;

         default: state_d = S_IDLE;
      endcase

      // Instruction boundary: start_i decides whether to keep running.
      if (retire) state_d = start_i ? S_FETCH : S_IDLE;
   end

   assign busy_o    = (state_q != S_IDLE) && (state_q != S_TRAP);
   assign illegal_o = (state_q == S_TRAP);
   assign retired_o = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: scoreboard bench for mc_control. Stimulus pushes the
// hand-written expected output vector for each driven cycle; a monitor
// pops and compares on the falling edge.
module tb_mc_control;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  op = 6'd0;
   logic        iready = 1'b0;
   logic        dready = 1'b0;
   logic        zero = 1'b0;
   logic        imem_req, ir_write, pc_write, pc_branch, reg_write, reg_dst;
   logic        alu_src, dmem_req, dmem_we, mem_to_reg, busy, illegal;
   logic [1:0]  alu_op;
   logic [31:0] retired;

   always #5 clk = ~clk;

   mc_control dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .op_i         (op),
      .imem_ready_i (iready),
      .dmem_ready_i (dready),
      .zero_i       (zero),
      .imem_req_o   (imem_req),
      .ir_write_o   (ir_write),
      .pc_write_o   (pc_write),
      .pc_branch_o  (pc_branch),
      .reg_write_o  (reg_write),
      .reg_dst_o    (reg_dst),
      .alu_src_o    (alu_src),
      .alu_op_o     (alu_op),
      .dmem_req_o   (dmem_req),
      .dmem_we_o    (dmem_we),
      .mem_to_reg_o (mem_to_reg),
      .busy_o       (busy),
      .illegal_o    (illegal),
      .retired_o    (retired)
   );

   localparam logic [5:0] RT = 6'b000000, ADDI = 6'b001000, LW = 6'b100011;
   localparam logic [5:0] SW = 6'b101011, BEQ = 6'b000100, BAD = 6'b111111;

   // {imem_req,ir_write,pc_write,pc_branch}_{reg_write,reg_dst,alu_src}_
   // {alu_op}_{dmem_req,dmem_we,mem_to_reg}_{busy,illegal}
   localparam logic [13:0] E_IDLE   = 14'b0000_000_00_000_00;
   localparam logic [13:0] E_FWAIT  = 14'b1000_000_00_000_10;
   localparam logic [13:0] E_FETCH  = 14'b1110_000_00_000_10;
   localparam logic [13:0] E_DEC    = 14'b0000_000_00_000_10;
   localparam logic [13:0] E_EX_R   = 14'b0000_000_10_000_10;
   localparam logic [13:0] E_EX_I   = 14'b0000_001_00_000_10;
   localparam logic [13:0] E_EX_B0  = 14'b0000_000_01_000_10;
   localparam logic [13:0] E_EX_B1  = 14'b0001_000_01_000_10;
   localparam logic [13:0] E_MEM_LW = 14'b0000_000_00_100_10;
   localparam logic [13:0] E_MEM_SW = 14'b0000_000_00_110_10;
   localparam logic [13:0] E_WB_R   = 14'b0000_110_00_000_10;
   localparam logic [13:0] E_WB_I   = 14'b0000_100_00_000_10;
   localparam logic [13:0] E_WB_LW  = 14'b0000_100_00_001_10;
   localparam logic [13:0] E_TRAP   = 14'b0000_000_00_000_01;

   typedef struct {
      logic [13:0] ov;
      logic [31:0] ret;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   logic [13:0] got_ov;
   assign got_ov = {imem_req, ir_write, pc_write, pc_branch, reg_write, reg_dst,
                    alu_src, alu_op, dmem_req, dmem_we, mem_to_reg, busy, illegal};

   // Monitor: one expected entry per driven cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (got_ov !== e.ov) begin
               failures++;
               $display("FAIL %s outputs got=%b exp=%b", e.nm, got_ov, e.ov);
            end
            checks++;
            if (retired !== e.ret) begin
               failures++;
               $display("FAIL %s retired got=%0d exp=%0d", e.nm, retired, e.ret);
            end
         end
      end
   end

   task automatic cyc(input logic st, input logic [5:0] o, input logic ir,
                      input logic dr, input logic z, input logic [13:0] ov,
                      input logic [31:0] ret, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst = 1'b0; start = st; op = o; iready = ir; dready = dr; zero = z;
      e.ov = ov; e.ret = ret; e.nm = nm;
      sb.push_back(e);
   endtask

   // Reset cycle; outputs of this cycle still reflect the pre-reset state.
   task automatic do_rst(input logic st, input logic [5:0] o, input logic dr);
      @(posedge clk);
      #1;
      rst = 1'b1; start = st; op = o; iready = 1'b1; dready = dr;
   endtask

   initial begin
      do_rst(1'b0, RT, 1'b0);
      cyc(0, RT, 1, 1, 0, E_IDLE, 0, "reset_idle");
      cyc(0, RT, 1, 1, 0, E_IDLE, 0, "idle_ignores_ready");
      // R-type add, zero wait
      cyc(1, RT, 1, 1, 0, E_IDLE,  0, "add_start");
      cyc(1, RT, 1, 1, 0, E_FETCH, 0, "add_fetch");
      cyc(1, RT, 1, 1, 0, E_DEC,   0, "add_decode");
      cyc(1, RT, 1, 1, 0, E_EX_R,  0, "add_exec");
      cyc(1, RT, 1, 1, 0, E_WB_R,  0, "add_wb");
      // addi
      cyc(1, ADDI, 1, 1, 0, E_FETCH, 1, "addi_fetch");
      cyc(1, ADDI, 1, 1, 0, E_DEC,   1, "addi_decode");
      cyc(1, ADDI, 1, 1, 0, E_EX_I,  1, "addi_exec");
      cyc(1, ADDI, 1, 1, 0, E_WB_I,  1, "addi_wb");
      // lw, one imem stall, three dmem stalls
      cyc(1, LW, 0, 1, 0, E_FWAIT,  2, "lw_fetch_wait");
      cyc(1, LW, 1, 1, 0, E_FETCH,  2, "lw_fetch");
      cyc(1, LW, 1, 1, 0, E_DEC,    2, "lw_decode");
      cyc(1, LW, 1, 1, 0, E_EX_I,   2, "lw_exec");
      cyc(1, LW, 1, 0, 0, E_MEM_LW, 2, "lw_mem_wait1");
      cyc(1, LW, 1, 0, 0, E_MEM_LW, 2, "lw_mem_wait2");
      cyc(1, LW, 1, 0, 0, E_MEM_LW, 2, "lw_mem_wait3");
      cyc(1, LW, 1, 1, 0, E_MEM_LW, 2, "lw_mem_done");
      cyc(1, LW, 1, 1, 0, E_WB_LW,  2, "lw_wb");
      // beq taken then not taken
      cyc(1, BEQ, 1, 1, 1, E_FETCH, 3, "beq1_fetch");
      cyc(1, BEQ, 1, 1, 1, E_DEC,   3, "beq1_decode");
      cyc(1, BEQ, 1, 1, 1, E_EX_B1, 3, "beq1_exec");
      cyc(1, BEQ, 1, 1, 0, E_FETCH, 4, "beq0_fetch");
      cyc(1, BEQ, 1, 1, 0, E_DEC,   4, "beq0_decode");
      cyc(1, BEQ, 1, 1, 0, E_EX_B0, 4, "beq0_exec");
      // sw with start dropped in EXEC: completes, then IDLE
      cyc(1, SW, 1, 1, 0, E_FETCH,  5, "sw_fetch");
      cyc(1, SW, 1, 1, 0, E_DEC,    5, "sw_decode");
      cyc(0, SW, 1, 1, 0, E_EX_I,   5, "sw_exec");
      cyc(0, SW, 1, 1, 0, E_MEM_SW, 5, "sw_mem");
      cyc(0, SW, 1, 1, 0, E_IDLE,   6, "sw_idle");
      cyc(0, SW, 1, 1, 0, E_IDLE,   6, "sw_idle_hold");
      // reset mid-MEM with lw in flight
      cyc(1, LW, 1, 1, 0, E_IDLE,   6, "lwr_start");
      cyc(1, LW, 1, 1, 0, E_FETCH,  6, "lwr_fetch");
      cyc(1, LW, 1, 1, 0, E_DEC,    6, "lwr_decode");
      cyc(1, LW, 1, 1, 0, E_EX_I,   6, "lwr_exec");
      do_rst(1'b1, LW, 1'b1);
      cyc(0, LW, 1, 1, 0, E_IDLE,   0, "lwr_after_reset");
      cyc(0, LW, 1, 1, 0, E_IDLE,   0, "lwr_no_wb");
      // reset on the same cycle as a sw retire: retire not counted
      cyc(1, SW, 1, 1, 0, E_IDLE,   0, "swr_start");
      cyc(1, SW, 1, 1, 0, E_FETCH,  0, "swr_fetch");
      cyc(1, SW, 1, 1, 0, E_DEC,    0, "swr_decode");
      cyc(1, SW, 1, 1, 0, E_EX_I,   0, "swr_exec");
      do_rst(1'b1, SW, 1'b1);
      cyc(0, SW, 1, 1, 0, E_IDLE,   0, "swr_after_reset");
      // illegal opcode traps and sticks
      cyc(1, BAD, 1, 1, 0, E_IDLE,  0, "trap_start");
      cyc(1, BAD, 1, 1, 0, E_FETCH, 0, "trap_fetch");
      cyc(1, BAD, 1, 1, 0, E_DEC,   0, "trap_decode");
      cyc(1, RT,  1, 1, 0, E_TRAP,  0, "trap_hold1");
      cyc(0, RT,  1, 1, 0, E_TRAP,  0, "trap_hold2");
      cyc(1, RT,  1, 1, 0, E_TRAP,  0, "trap_hold3");
      do_rst(1'b0, RT, 1'b0);
      cyc(0, RT, 1, 1, 0, E_IDLE,   0, "trap_cleared");

      @(posedge clk);
      #1;
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
